ps2_host_tx: RTL
================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard.
//  Drives open-collector PS2C/PS2D through active-high pull-low enables; the top level owns the tri-states.
//  Companion to the PS/2 scan-code receiver on the same lines. busy gates that receiver while a frame is in flight.
// PARAMETERS
//  INHIBIT_CYCLES  10000    clk cycles PS2C is held low before the request-to-send (100 us @ 100 MHz)
//  TIMEOUT_CYCLES  2000000  max clk cycles from clock release to ACK/idle (20 ms @ 100 MHz)
//  FILTER_LEN      8        glitch-filter depth on PS2C/PS2D samples
// PORTS
//  clk       in   1  system clock
//  rst       in   1  asynchronous reset, active high
//  PS2C      in   1  PS/2 clock line, sampled (pad value)
//  PS2D      in   1  PS/2 data line, sampled (pad value)
//  tx_data   in   8  command byte to send
//  tx_valid  in   1  request; accepted when tx_valid && tx_ready
//  tx_ready  out  1  high only in IDLE
//  ps2c_low  out  1  1 = pull PS2C low; 0 = release (pull-up)
//  ps2d_low  out  1  1 = pull PS2D low; 0 = release
//  busy      out  1  high in every state except IDLE
//  done      out  1  one-cycle pulse: frame sent and ACK seen
//  err       out  1  one-cycle pulse: missing ACK or timeout
// BEHAVIOUR
//  Reset: ps2c_low=ps2d_low=0, done=err=0, busy=0, tx_ready=1, state=IDLE. Filters clear; filtered lines =1.
//  Reset mid-frame releases both lines on the same edge as rst. No partial bits are resumed.
//  Filter: FILTER_LEN-sample shift per line. All ones ->1, all zeros ->0, else hold.
//  fall = filtered PS2C 1->0 registered in clk domain. No logic is clocked by PS2C.
//  Accept: latch tx_data; parity = ~^tx_data (odd). Bit counter cnt=0. Go to INHIBIT.
//  INHIBIT: ps2c_low=1, ps2d_low=0 for INHIBIT_CYCLES cycles. Then ps2d_low=1 (start bit) for 1 cycle -> REQ.
//  REQ: ps2c_low=0, ps2d_low=1. Timeout counter starts. On fall -> SEND.
//  SEND: on each fall, drive the next bit (ps2d_low = ~bit).
//    Falls 1-8: data[0..7], LSB first. Fall 9: parity. Fall 10: stop bit (ps2d_low=0). Then -> ACK.
//    Data is changed only on fall, so it is stable while PS2C is low.
//  ACK: on fall 11, sample filtered PS2D. 0 -> WAIT_IDLE. 1 -> FAIL (NACK).
//  WAIT_IDLE: wait until filtered PS2C=1 and PS2D=1. Then pulse done, go IDLE.
//  FAIL: release lines, pulse err, go IDLE (see CONFIGURATION).
//  Timeout: counter runs REQ..WAIT_IDLE. Reaching TIMEOUT_CYCLES -> FAIL from any of those states.
//  Timeout beats a same-cycle fall.
//  tx_valid outside IDLE is ignored, with no queueing. done and err are never high together.
//  Counters sized $clog2(param+1). No wrap: each counter saturates and stops at its terminal count.
// CONFIGURATION
//  PS2_TX_RETRY_EN defined: the first FAIL of an accepted byte re-enters INHIBIT with the same byte.
//    Retry flag is cleared on accept. err pulses only on the second failure. done after a successful retry.
//  Not defined: FAIL always pulses err and returns to IDLE. No retry logic is synthesized.
// TESTING
//  1 tx 0xED, device model clocks at 12.5 kHz and ACKs.
//    -> PS2C low >= INHIBIT_CYCLES, then start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
//    -> done pulse once, err=0, tx_ready=1 after.
//  2 tx 0x01 and 0xFF -> parity bits 0 and 1 respectively; both done.
//  3 device leaves PS2D high at fall 11.
//    -> no RETRY_EN: err pulse, lines released.
//    -> RETRY_EN: second full frame, then err.
//  4 device never clocks -> err exactly TIMEOUT_CYCLES after REQ entry; ps2c_low=ps2d_low=0.
//  5 rst asserted after fall 4 -> ps2c_low=ps2d_low=0 and tx_ready=1 with no clk edge. Next tx 0xF4 succeeds.
//  6 3-cycle low glitch on PS2C during SEND -> no bit advance.
//    tx_valid during busy -> ignored, byte not sent.

Source files
------------

// File: rtl/ps2_host_tx_if.sv
// Command handshake and status bundle between a PS/2 host transmitter and its client.
// The client drives the master side; ps2_host_tx implements the slave side.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       err;

  modport master (output tx_data, tx_valid, input tx_ready, busy, done, err);
  modport slave  (input tx_data, tx_valid, output tx_ready, busy, done, err);
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter driving open-collector pull-low enables.
// Optional macro PS2_TX_RETRY_EN: one automatic retry of a failed byte before err.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILTER_LEN     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          PS2C,
  input  logic          PS2D,
  ps2_host_tx_if.slave  tx,
  output logic          ps2c_low,
  output logic          ps2d_low
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [INH_W-1:0] INH_MAX  = INH_W'(INHIBIT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_START, S_REQ, S_SEND, S_ACK, S_WAIT_IDLE, S_FAIL
  } state_t;

  state_t            state_q, state_d;
  logic [8:0]        frame_q, frame_d;   // {parity, data}
  logic [3:0]        cnt_q, cnt_d;
  logic [INH_W-1:0]  inh_q, inh_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d, tmo_nxt;
  logic              done_q, done_d;
  logic              err_c, tmo_hit;

  logic [FILTER_LEN-1:0] csh_q, dsh_q;
  logic                  cf_q, df_q, cf_prev_q;
  logic                  fall;

  // Line filters: a level is only believed after FILTER_LEN identical samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csh_q     <= '1;
      dsh_q     <= '1;
      cf_q      <= 1'b1;
      df_q      <= 1'b1;
      cf_prev_q <= 1'b1;
    end else begin
      csh_q     <= {csh_q[FILTER_LEN-2:0], PS2C};
      dsh_q     <= {dsh_q[FILTER_LEN-2:0], PS2D};
      if (&csh_q)          cf_q <= 1'b1;
      else if (csh_q == '0) cf_q <= 1'b0;
      if (&dsh_q)          df_q <= 1'b1;
      else if (dsh_q == '0) df_q <= 1'b0;
      cf_prev_q <= cf_q;
    end
  end

  assign fall = cf_prev_q & ~cf_q;

`ifdef PS2_TX_RETRY_EN
  logic retry_q, retry_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      frame_q <= '0;
      cnt_q   <= '0;
      inh_q   <= '0;
      tmo_q   <= '0;
      done_q  <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
      inh_q   <= inh_d;
      tmo_q   <= tmo_d;
      done_q  <= done_d;
`ifdef PS2_TX_RETRY_EN
      retry_q <= retry_d;
`endif
    end
  end

  // Timeout spans REQ..WAIT_IDLE; it is cleared in every other state.
  assign tmo_nxt = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;
  assign tmo_hit = (tmo_nxt == TMO_MAX);

  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    cnt_d    = cnt_q;
    inh_d    = '0;
    tmo_d    = '0;
    done_d   = 1'b0;
    err_c    = 1'b0;
    ps2c_low = 1'b0;
    ps2d_low = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_d  = retry_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (tx.tx_valid) begin
          frame_d = {~^tx.tx_data, tx.tx_data};
          cnt_d   = '0;
          state_d = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
          retry_d = 1'b0;
`endif
        end
      end
      S_INHIBIT: begin
        ps2c_low = 1'b1;
        inh_d    = (inh_q == INH_MAX) ? inh_q : inh_q + 1'b1;
        if (inh_q == INH_LAST) state_d = S_START;
      end
      S_START: begin
        ps2c_low = 1'b1;
        ps2d_low = 1'b1;
        state_d  = S_REQ;
      end
      S_REQ: begin
        ps2d_low = 1'b1;
        tmo_d    = tmo_nxt;
        cnt_d    = '0;
        if (tmo_hit)   state_d = S_FAIL;
        else if (fall) state_d = S_SEND;
      end
      S_SEND: begin
        // Bit index only moves on a fall, so data is stable while PS2C is low.
        ps2d_low = ~frame_q[cnt_q];
        tmo_d    = tmo_nxt;
        if (tmo_hit) state_d = S_FAIL;
        else if (fall) begin
          if (cnt_q == 4'd8) state_d = S_ACK;
          else               cnt_d   = cnt_q + 4'd1;
        end
      end
      S_ACK: begin
        tmo_d = tmo_nxt;
        if (tmo_hit)   state_d = S_FAIL;
        else if (fall) state_d = df_q ? S_FAIL : S_WAIT_IDLE;
      end
      S_WAIT_IDLE: begin
        tmo_d = tmo_nxt;
        if (tmo_hit) state_d = S_FAIL;
        else if (cf_q && df_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_FAIL: begin
`ifdef PS2_TX_RETRY_EN
        if (!retry_q) begin
          retry_d = 1'b1;
          state_d = S_INHIBIT;
        end else begin
          err_c   = 1'b1;
          state_d = S_IDLE;
        end
`else
        err_c   = 1'b1;
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tx.tx_ready = (state_q == S_IDLE);
  assign tx.busy     = (state_q != S_IDLE);
  assign tx.done     = done_q;
  assign tx.err      = err_c;

endmodule
